// File: rtl/rr_alloc_ctrl.sv
// Row-redundancy allocation controller: matches incoming faulty rows against
// four spare-row registers and assigns uncovered faults to the lowest free spare.
module rr_alloc_ctrl #(
    parameter int ADDR_W = 10,
    parameter int BLK_W  = 2,
    localparam int W     = ADDR_W + BLK_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         fault_valid,
    output logic         fault_ready,
    input  logic [W-1:0] fault_addr,
    input  logic         test_end,
    output logic [W-1:0] RRx1,
    output logic [W-1:0] RRx2,
    output logic [W-1:0] RRx3,
    output logic [W-1:0] RRx4,
    output logic [3:0]   RLSS,
    output logic [7:0]   hit_cnt,
    output logic         busy,
    output logic         done,
    output logic         unrepairable
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ALLOC,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] npr_q, npr_d;
    logic [W-1:0] rrx_q [4];
    logic [W-1:0] rrx_d [4];
    logic [3:0]   rlss_q, rlss_d;
    logic [7:0]   hit_cnt_q, hit_cnt_d;
    logic [3:0]   match;
    logic         hit;
    logic [1:0]   free_idx;
    logic         do_clear;

    // Unused spares hold 0; the in-use flag gates the compare so they never match.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_match
            assign match[gi] = rlss_q[gi] && (rrx_q[gi] == npr_q);
        end
    endgenerate

    assign hit = |match;

    always_comb begin
        free_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rlss_q[i]) free_idx = 2'(i);
        end
    end

    assign fault_ready = (state_q == ST_IDLE) && !test_end;
    assign do_clear    = clear && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                   (state_q == ST_FAIL));

    always_comb begin
        state_d   = state_q;
        npr_d     = npr_q;
        rrx_d     = rrx_q;
        rlss_d    = rlss_q;
        hit_cnt_d = hit_cnt_q;
        if (do_clear) begin
            state_d   = ST_IDLE;
            npr_d     = '0;
            rlss_d    = '0;
            hit_cnt_d = '0;
            for (int i = 0; i < 4; i++) rrx_d[i] = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (test_end) begin
                        state_d = ST_DONE;
                    end else if (fault_valid) begin
                        npr_d   = fault_addr;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
                        state_d = ST_IDLE;
                    end else if (rlss_q != 4'b1111) begin
                        state_d = ST_ALLOC;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
                ST_ALLOC: begin
                    rrx_d[free_idx]  = npr_q;
                    rlss_d[free_idx] = 1'b1;
                    state_d          = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            npr_q     <= '0;
            rlss_q    <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            npr_q     <= npr_d;
            rlss_q    <= rlss_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) rrx_q[gi] <= '0;
                else     rrx_q[gi] <= rrx_d[gi];
            end
        end
    endgenerate

    assign RRx1         = rrx_q[0];
    assign RRx2         = rrx_q[1];
    assign RRx3         = rrx_q[2];
    assign RRx4         = rrx_q[3];
    assign RLSS         = rlss_q;
    assign hit_cnt      = hit_cnt_q;
    assign busy         = (state_q == ST_CHECK) || (state_q == ST_ALLOC);
    assign done         = (state_q == ST_DONE);
    assign unrepairable = (state_q == ST_FAIL);

endmodule

// File: tb/tb_rr_alloc_ctrl.sv
// Directed bench for rr_alloc_ctrl with hand-computed expectations.
module tb_rr_alloc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        fault_valid = 1'b0;
    logic        fault_ready;
    logic [11:0] fault_addr = '0;
    logic        test_end = 1'b0;
    logic [11:0] RRx1, RRx2, RRx3, RRx4;
    logic [3:0]  RLSS;
    logic [7:0]  hit_cnt;
    logic        busy, done, unrepairable;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    rr_alloc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .fault_valid  (fault_valid),
        .fault_ready  (fault_ready),
        .fault_addr   (fault_addr),
        .test_end     (test_end),
        .RRx1         (RRx1),
        .RRx2         (RRx2),
        .RRx3         (RRx3),
        .RRx4         (RRx4),
        .RLSS         (RLSS),
        .hit_cnt      (hit_cnt),
        .busy         (busy),
        .done         (done),
        .unrepairable (unrepairable)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry from IDLE; returns edges after acceptance until ready returns.
    task automatic send(input logic [11:0] a, output int l);
        fault_addr  = a;
        fault_valid = 1'b1;
        tick();
        fault_valid = 1'b0;
        l = 0;
        while (!fault_ready && l < 10) begin
            tick();
            l++;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        tick();
        rst = 1'b0;
        tick();
        check_eq("rst_rlss", RLSS, 0);
        check_eq("rst_rrx1", RRx1, 0);
        check_eq("rst_hit", hit_cnt, 0);
        check_eq("rst_ready", fault_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_unrep", unrepairable, 0);

        // Four distinct faults fill the spares in order
        send(12'h004, lat); check_eq("fill_lat1", lat, 2);
        send(12'h008, lat); check_eq("fill_lat2", lat, 2);
        send(12'h00C, lat); check_eq("fill_lat3", lat, 2);
        send(12'h010, lat); check_eq("fill_lat4", lat, 2);
        check_eq("fill_rrx1", RRx1, 12'h004);
        check_eq("fill_rrx2", RRx2, 12'h008);
        check_eq("fill_rrx3", RRx3, 12'h00C);
        check_eq("fill_rrx4", RRx4, 12'h010);
        check_eq("fill_rlss", RLSS, 4'b1111);
        check_eq("fill_hit", hit_cnt, 0);
        do_clear();
        check_eq("clr_rlss", RLSS, 0);
        check_eq("clr_rrx4", RRx4, 0);

        // Repeated fault: one allocation, then hits
        send(12'h004, lat); check_eq("dup_lat1", lat, 2);
        send(12'h004, lat); check_eq("dup_lat2", lat, 1);
        send(12'h004, lat); check_eq("dup_lat3", lat, 1);
        check_eq("dup_rrx1", RRx1, 12'h004);
        check_eq("dup_rrx2", RRx2, 0);
        check_eq("dup_rlss", RLSS, 4'b0001);
        check_eq("dup_hit", hit_cnt, 2);
        do_clear();

        // Same address, different block takes a new spare
        send(12'h004, lat);
        send(12'h005, lat);
        check_eq("blk_rlss", RLSS, 4'b0011);
        check_eq("blk_rrx2", RRx2, 12'h005);
        check_eq("blk_hit", hit_cnt, 0);
        do_clear();

        // Fifth distinct fault makes the memory unrepairable
        send(12'h100, lat);
        send(12'h101, lat);
        send(12'h102, lat);
        send(12'h103, lat);
        fault_addr  = 12'h104;
        fault_valid = 1'b1;
        tick();
        fault_valid = 1'b0;
        check_eq("full_busy", busy, 1);
        check_eq("full_unrep_early", unrepairable, 0);
        tick();
        check_eq("full_unrep", unrepairable, 1);
        check_eq("full_rlss", RLSS, 4'b1111);
        check_eq("full_ready", fault_ready, 0);
        fault_addr  = 12'h100;
        fault_valid = 1'b1;
        tick();
        fault_valid = 1'b0;
        check_eq("full_sticky", unrepairable, 1);
        check_eq("full_hit", hit_cnt, 0);
        do_clear();
        check_eq("fclr_unrep", unrepairable, 0);
        check_eq("fclr_rlss", RLSS, 0);
        check_eq("fclr_ready", fault_ready, 1);

        // test_end wins over a simultaneous fault offer
        test_end    = 1'b1;
        fault_valid = 1'b1;
        fault_addr  = 12'h3FF;
        #1;
        check_eq("te_ready_comb", fault_ready, 0);
        tick();
        test_end    = 1'b0;
        fault_valid = 1'b0;
        check_eq("te_done", done, 1);
        check_eq("te_busy", busy, 0);
        check_eq("te_ready", fault_ready, 0);
        tick();
        check_eq("te_rlss", RLSS, 0);
        check_eq("te_done_hold", done, 1);
        do_clear();
        check_eq("te_clr_done", done, 0);
        // clear has priority over test_end
        clear    = 1'b1;
        test_end = 1'b1;
        tick();
        clear    = 1'b0;
        test_end = 1'b0;
        #1;
        check_eq("clr_te_done", done, 0);
        check_eq("clr_te_ready", fault_ready, 1);

        // Asynchronous reset while in ALLOC
        fault_addr  = 12'h123;
        fault_valid = 1'b1;
        tick();
        fault_valid = 1'b0;
        tick();
        check_eq("ar_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("ar_busy_rst", busy, 0);
        check_eq("ar_rlss", RLSS, 0);
        check_eq("ar_rrx1", RRx1, 0);
        check_eq("ar_ready", fault_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        check_eq("ar_rlss_after", RLSS, 0);
        check_eq("ar_rrx1_after", RRx1, 0);

        // Hit counter saturation
        send(12'h2A1, lat);
        for (int i = 0; i < 255; i++) send(12'h2A1, lat);
        check_eq("sat_hit_255", hit_cnt, 255);
        for (int i = 0; i < 45; i++) send(12'h2A1, lat);
        check_eq("sat_hit_300", hit_cnt, 255);
        check_eq("sat_rlss", RLSS, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
